// File: rtl/dco_freq_ctrl.sv
// DCO frequency control loop: counts DCO rising edges per clk_i window and steps freq_sel_o toward target_i.
// Define DCO_FREQ_CTRL_LOCK_HOLD_EN to freeze freq_sel_o while locked and deviation stays within 2*TOL.
module dco_freq_ctrl #(
   parameter int unsigned CTRL_WIDTH    = 5,
   parameter int unsigned CNT_WIDTH     = 16,
   parameter int unsigned WINDOW_CYCLES = 256,
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned TOL           = 2,
   parameter int unsigned LOCK_WINDOWS  = 4,
   parameter int unsigned FSEL_INIT     = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   input  logic                  dco_clk_i,
   input  logic [CNT_WIDTH-1:0]  target_i,
   output logic [CTRL_WIDTH-1:0] freq_sel_o,
   output logic                  dco_enable_o,
   output logic [CNT_WIDTH-1:0]  meas_count_o,
   output logic                  meas_valid_o,
   output logic                  locked_o
);
   localparam int unsigned EXT_W = CNT_WIDTH + 1;
   localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES + 1);
   localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned LCK_W = $clog2(LOCK_WINDOWS + 1);

   localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
   localparam logic [EXT_W-1:0]      CNT_MAX_X = {1'b0, CNT_MAX};
   localparam logic [EXT_W-1:0]      TOL_X     = EXT_W'(TOL);
   localparam logic [CTRL_WIDTH-1:0] FSEL_MAX  = {CTRL_WIDTH{1'b1}};
   localparam logic [CTRL_WIDTH-1:0] FSEL_RST  = CTRL_WIDTH'(FSEL_INIT);
   localparam logic [WIN_W-1:0]      WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
   localparam logic [SET_W-1:0]      SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
   localparam logic [LCK_W-1:0]      LCK_FULL  = LCK_W'(LOCK_WINDOWS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_MEASURE,
      ST_ADJUST
   } state_e;

   state_e                  state_q;
   logic                    sync1_q;
   logic                    sync2_q;
   logic                    dco_prev_q;
   logic                    edge_c;
   logic [SET_W-1:0]        settle_cnt_q;
   logic [WIN_W-1:0]        win_cnt_q;
   logic [CNT_WIDTH-1:0]    edge_cnt_q;
   logic [LCK_W-1:0]        lock_cnt_q;

   logic [EXT_W-1:0]        cnt_x;
   logic [EXT_W-1:0]        tgt_x;
   logic [EXT_W-1:0]        lo_x;
   logic [EXT_W-1:0]        hi_sum_x;
   logic [EXT_W-1:0]        hi_x;
   logic                    too_slow_c;
   logic                    too_fast_c;
   logic                    hold_c;
   logic                    step_c;
   logic [CTRL_WIDTH-1:0]   freq_sel_d;
   logic [LCK_W-1:0]        lock_cnt_d;
   logic                    locked_d;

   // Two-flop synchronizer plus one history flop for rising-edge detection
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q    <= 1'b0;
         sync2_q    <= 1'b0;
         dco_prev_q <= 1'b0;
      end else begin
         sync1_q    <= dco_clk_i;
         sync2_q    <= sync1_q;
         dco_prev_q <= sync2_q;
      end
   end

   assign edge_c = sync2_q & ~dco_prev_q;

   // Tolerance bounds are formed one bit wider so neither clamp can wrap
   assign cnt_x      = {1'b0, edge_cnt_q};
   assign tgt_x      = {1'b0, target_i};
   assign lo_x       = (tgt_x >= TOL_X) ? (tgt_x - TOL_X) : '0;
   assign hi_sum_x   = tgt_x + TOL_X;
   assign hi_x       = (hi_sum_x > CNT_MAX_X) ? CNT_MAX_X : hi_sum_x;
   assign too_slow_c = (cnt_x < lo_x);
   assign too_fast_c = (cnt_x > hi_x);

`ifdef DCO_FREQ_CTRL_LOCK_HOLD_EN
   logic [EXT_W-1:0] dev_x;
   assign dev_x  = (cnt_x >= tgt_x) ? (cnt_x - tgt_x) : (tgt_x - cnt_x);
   assign hold_c = locked_o && (dev_x <= EXT_W'(2 * TOL));
`else
   assign hold_c = 1'b0;
`endif

   // Window decision applied in ADJUST: step the select word or advance the lock count
   always_comb begin
      freq_sel_d = freq_sel_o;
      lock_cnt_d = lock_cnt_q;
      locked_d   = locked_o;
      if (!hold_c) begin
         if (too_slow_c) begin
            if (freq_sel_o != FSEL_MAX) begin
               freq_sel_d = freq_sel_o + CTRL_WIDTH'(1);
            end
            lock_cnt_d = '0;
            locked_d   = 1'b0;
         end else if (too_fast_c) begin
            if (freq_sel_o != '0) begin
               freq_sel_d = freq_sel_o - CTRL_WIDTH'(1);
            end
            lock_cnt_d = '0;
            locked_d   = 1'b0;
         end else begin
            if (lock_cnt_q != LCK_FULL) begin
               lock_cnt_d = lock_cnt_q + LCK_W'(1);
            end
            locked_d = (lock_cnt_d == LCK_FULL);
         end
      end
   end

   assign step_c = (freq_sel_d != freq_sel_o);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         freq_sel_o   <= FSEL_RST;
         dco_enable_o <= 1'b0;
         meas_count_o <= '0;
         meas_valid_o <= 1'b0;
         locked_o     <= 1'b0;
         settle_cnt_q <= '0;
         win_cnt_q    <= '0;
         edge_cnt_q   <= '0;
         lock_cnt_q   <= '0;
      end else begin
         meas_valid_o <= 1'b0;
         if (!enable_i) begin
            // Disable wins in every state; any partial window is dropped
            state_q      <= ST_IDLE;
            dco_enable_o <= 1'b0;
            locked_o     <= 1'b0;
            lock_cnt_q   <= '0;
            settle_cnt_q <= '0;
            win_cnt_q    <= '0;
            edge_cnt_q   <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  state_q      <= ST_SETTLE;
                  dco_enable_o <= 1'b1;
                  settle_cnt_q <= '0;
               end
               ST_SETTLE: begin
                  if (settle_cnt_q == SET_LAST) begin
                     state_q    <= ST_MEASURE;
                     win_cnt_q  <= '0;
                     edge_cnt_q <= '0;
                  end else begin
                     settle_cnt_q <= settle_cnt_q + SET_W'(1);
                  end
               end
               ST_MEASURE: begin
                  if (edge_c && (edge_cnt_q != CNT_MAX)) begin
                     edge_cnt_q <= edge_cnt_q + CNT_WIDTH'(1);
                  end
                  if (win_cnt_q == WIN_LAST) begin
                     state_q <= ST_ADJUST;
                  end else begin
                     win_cnt_q <= win_cnt_q + WIN_W'(1);
                  end
               end
               ST_ADJUST: begin
                  meas_count_o <= edge_cnt_q;
                  meas_valid_o <= 1'b1;
                  freq_sel_o   <= freq_sel_d;
                  lock_cnt_q   <= lock_cnt_d;
                  locked_o     <= locked_d;
                  win_cnt_q    <= '0;
                  edge_cnt_q   <= '0;
                  settle_cnt_q <= '0;
                  state_q      <= step_c ? ST_SETTLE : ST_MEASURE;
               end
               default: begin
                  state_q <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/dco_freq_ctrl.md
DCO_FREQ_CTRL -- requirements
Module: dco_freq_ctrl

Interface
REQ-001 Parameter CTRL_WIDTH, default 5: width of DCO frequency-select word.
REQ-002 Parameter CNT_WIDTH, default 16: width of edge counter, target and measurement.
REQ-003 Parameter WINDOW_CYCLES, default 256: clk_i cycles per measurement window.
REQ-004 Parameter SETTLE_CYCLES, default 16: clk_i cycles waited after any DCO enable or select change.
REQ-005 Parameter TOL, default 2: allowed |count - target| for an in-tolerance window.
REQ-006 Parameter LOCK_WINDOWS, default 4: consecutive in-tolerance windows needed to assert lock.
REQ-007 Parameter FSEL_INIT, default 0: reset value of freq_sel_o.
REQ-008 clk_i  input  1: system clock; all state on its rising edge; the block has one clock.
REQ-009 rst_i  input  1: reset, asynchronous, active-high.
REQ-010 enable_i  input  1: run control loop.
REQ-011 dco_clk_i  input  1: DCO output, asynchronous to clk_i, sampled as data.
REQ-012 target_i  input  CNT_WIDTH: required DCO rising edges per window.
REQ-013 freq_sel_o  output  CTRL_WIDTH: DCO select word; higher value means higher DCO frequency.
REQ-014 dco_enable_o  output  1: DCO enable.
REQ-015 meas_count_o  output  CNT_WIDTH: last completed window edge count.
REQ-016 meas_valid_o  output  1: one-cycle pulse when meas_count_o updates.
REQ-017 locked_o  output  1: frequency lock indication.

Function
REQ-018 dco_clk_i passes a 2-flop synchronizer then a rising-edge detector; one detected edge increments the edge counter by 1, saturating at 2^CNT_WIDTH-1; DCO frequency below clk_i/2 is required for exact counts.
REQ-019 FSM states IDLE, SETTLE, MEASURE, ADJUST; IDLE after reset.
REQ-020 IDLE: dco_enable_o=0; enable_i=1 -> SETTLE next cycle, dco_enable_o=1 from that cycle.
REQ-021 SETTLE: counts SETTLE_CYCLES cycles, then MEASURE; edge and window counters cleared on entry to MEASURE.
REQ-022 MEASURE: exactly WINDOW_CYCLES cycles of edge counting, then ADJUST.
REQ-023 ADJUST (one cycle): meas_count_o <= edge count, meas_valid_o=1 in the following cycle.
REQ-024 Compare bounds computed at CNT_WIDTH+1 bits; lower bound clamps at 0, upper at 2^CNT_WIDTH-1; no wrap.
REQ-025 count < target_i-TOL: freq_sel_o +1, saturating at 2^CTRL_WIDTH-1; count > target_i+TOL: freq_sel_o -1, saturating at 0; either case clears lock counter and locked_o.
REQ-026 In tolerance: freq_sel_o unchanged, lock counter +1 (saturating); locked_o=1 when counter reaches LOCK_WINDOWS.
REQ-027 After ADJUST: SETTLE if freq_sel_o changed, else MEASURE directly; saturated no-change step goes to MEASURE.
REQ-028 enable_i=0 in any state -> IDLE next cycle; dco_enable_o=0, locked_o=0, lock counter 0, partial window discarded (no meas_valid_o); freq_sel_o retains value.
REQ-029 target_i sampled only in ADJUST; changes mid-window take effect at next window end.

Reset
REQ-030 rst_i=1 asynchronously forces: state IDLE, freq_sel_o=FSEL_INIT, dco_enable_o=0, meas_count_o=0, meas_valid_o=0, locked_o=0, all counters and synchronizer flops 0.
REQ-031 Reset mid-window discards the window; operation restarts from IDLE after release.

Configuration
REQ-032 Macro DCO_FREQ_CTRL_LOCK_HOLD_EN defined: while locked_o=1, freq_sel_o frozen; windows deviating by at most 2*TOL keep lock; deviation beyond 2*TOL clears locked_o and resumes stepping per REQ-025 in that ADJUST.
REQ-033 Macro undefined: REQ-025/REQ-026 apply unconditionally, locked or not.

Verification (defaults, clk_i 100 MHz)
REQ-034 rst_i pulse mid-MEASURE -> all outputs at REQ-030 values immediately, no meas_valid_o.
REQ-035 DCO model 10 MHz, target_i=25, enable_i=1 -> meas_count_o=25 or 26 each window; locked_o rises at 4th valid pulse; freq_sel_o stays FSEL_INIT.
REQ-036 DCO model f = 2 MHz*(freq_sel+1), target_i=51 -> freq_sel_o steps +1 per window to 9 (count~51), then locked_o=1 after 4 further windows.
REQ-037 target_i=0xFFFF, freq_sel_o at 31 -> stays 31, no wrap; target_i=0, freq_sel_o 0 -> stays 0.
REQ-038 enable_i dropped mid-window -> IDLE next cycle, dco_enable_o=0, locked_o=0, freq_sel_o unchanged.
REQ-039 With DCO_FREQ_CTRL_LOCK_HOLD_EN, locked, count off by 3 -> lock kept, freq_sel_o frozen; off by 5 -> locked_o=0, freq_sel_o steps once.
